// File: rtl/vga_fill_ctrl.sv
// Write-port arbiter for the 80x60 frame buffer: CPU pixel writes always win,
// and a rectangle-fill engine uses the cycles the CPU leaves free.
module vga_fill_ctrl #(
    parameter int unsigned H_PIX = 80,
    parameter int unsigned V_PIX = 60,
    parameter int unsigned XW    = 7,
    parameter int unsigned YW    = 6,
    parameter int unsigned DW    = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CPU_WE,
    input  logic [XW+YW-1:0]     CPU_WA,
    input  logic [DW-1:0]        CPU_WD,
    input  logic                 START,
    input  logic [XW-1:0]        X0,
    input  logic [XW-1:0]        X1,
    input  logic [YW-1:0]        Y0,
    input  logic [YW-1:0]        Y1,
    input  logic [DW-1:0]        COLOR,
    output logic                 FB_WE,
    output logic [XW+YW-1:0]     FB_WA,
    output logic [DW-1:0]        FB_WD,
    output logic                 BUSY,
    output logic                 DONE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [XW-1:0]      x0_q, x0_d;
    logic [XW-1:0]      x1_q, x1_d;
    logic [YW-1:0]      y1_q, y1_d;
    logic [DW-1:0]      col_q, col_d;
    logic               from_fill_q, from_fill_d;
    logic               fb_we_q, fb_we_d;
    logic [XW+YW-1:0]   fb_wa_q, fb_wa_d;
    logic [DW-1:0]      fb_wd_q, fb_wd_d;
    logic               done_q, done_d;

    logic [XW-1:0]      x1_clamp;
    logic [YW-1:0]      y1_clamp;
    logic               rect_empty;

    // Clamp the far corner to the visible area before the emptiness test.
    always_comb begin
        x1_clamp   = (32'(X1) > H_PIX - 1) ? XW'(H_PIX - 1) : X1;
        y1_clamp   = (32'(Y1) > V_PIX - 1) ? YW'(V_PIX - 1) : Y1;
        rect_empty = (X0 > x1_clamp) || (Y0 > y1_clamp) ||
                     (32'(X0) >= H_PIX) || (32'(Y0) >= V_PIX);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            col_q       <= '0;
            from_fill_q <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_wa_q     <= '0;
            fb_wd_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            col_q       <= col_d;
            from_fill_q <= from_fill_d;
            fb_we_q     <= fb_we_d;
            fb_wa_q     <= fb_wa_d;
            fb_wd_q     <= fb_wd_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        col_d       = col_q;
        from_fill_d = from_fill_q;
        fb_we_d     = 1'b0;
        fb_wa_d     = fb_wa_q;
        fb_wd_d     = fb_wd_q;
        done_d      = 1'b0;

        if (CPU_WE) begin
            fb_we_d = 1'b1;
            fb_wa_d = CPU_WA;
            fb_wd_d = CPU_WD;
        end

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    x0_d        = X0;
                    x1_d        = x1_clamp;
                    y1_d        = y1_clamp;
                    col_d       = COLOR;
                    from_fill_d = !rect_empty;
                    // An empty fill signals DONE in the very next cycle.
                    if (rect_empty) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        x_d     = X0;
                        y_d     = Y0;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (!CPU_WE) begin
                    fb_we_d = 1'b1;
                    fb_wa_d = {y_q, x_q};
                    fb_wd_d = col_q;
                    if (x_q == x1_q && y_q == y1_q) begin
                        state_d = FIN;
                    end else if (x_q == x1_q) begin
                        x_d = x0_q;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            FIN: begin
                // DONE is registered so it follows the last visible fill write.
                done_d  = from_fill_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY  = (state_q == FILL) || (state_q == FIN && from_fill_q);
        DONE  = done_q;
        FB_WE = fb_we_q;
        FB_WA = fb_wa_q;
        FB_WD = fb_wd_q;
    end

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Directed bench for vga_fill_ctrl: fills, CPU contention, clamp, empty rect,
// restart-while-busy, single pixel and mid-fill reset.
module tb_vga_fill_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_WE;
    logic [12:0] CPU_WA;
    logic [7:0]  CPU_WD;
    logic        START;
    logic [6:0]  X0, X1;
    logic [5:0]  Y0, Y1;
    logic [7:0]  COLOR;
    logic        FB_WE;
    logic [12:0] FB_WA;
    logic [7:0]  FB_WD;
    logic        BUSY;
    logic        DONE;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct packed {
        int          cyc;
        logic [12:0] wa;
        logic [7:0]  wd;
    } wr_t;

    wr_t exp_q[$];

    vga_fill_ctrl #(.H_PIX(80), .V_PIX(60), .XW(7), .YW(6), .DW(8)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .CPU_WE (CPU_WE),
        .CPU_WA (CPU_WA),
        .CPU_WD (CPU_WD),
        .START  (START),
        .X0     (X0),
        .X1     (X1),
        .Y0     (Y0),
        .Y1     (Y1),
        .COLOR  (COLOR),
        .FB_WE  (FB_WE),
        .FB_WA  (FB_WA),
        .FB_WD  (FB_WD),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_wr(input int cyc, input logic [12:0] wa, input logic [7:0] wd);
        wr_t w;
        w.cyc = cyc;
        w.wa  = wa;
        w.wd  = wd;
        exp_q.push_back(w);
    endtask

    // Entered just after a rising edge; cycle 0 is the START cycle.
    // After cycle 0 the config ports carry a large junk rectangle that must be ignored.
    task automatic run_case(input string tag,
                            input logic [6:0] x0, input logic [6:0] x1,
                            input logic [5:0] y0, input logic [5:0] y1,
                            input logic [7:0] col,
                            input int cpu_cyc, input logic [12:0] cpu_wa, input logic [7:0] cpu_wd,
                            input int restart_cyc, input int rst_cyc,
                            input int busy_lo, input int busy_hi,
                            input int done_cyc, input int ncyc);
        int idx = 0;
        logic exp_we;
        for (int c = 0; c < ncyc; c++) begin
            START  = (c == 0) || (c == restart_cyc);
            RST    = (c == rst_cyc);
            CPU_WE = (c == cpu_cyc);
            CPU_WA = (c == cpu_cyc) ? cpu_wa : 13'h1FFF;
            CPU_WD = (c == cpu_cyc) ? cpu_wd : 8'hAA;
            if (c == 0) begin
                X0 = x0; X1 = x1; Y0 = y0; Y1 = y1; COLOR = col;
            end else begin
                X0 = 7'd0; X1 = 7'd127; Y0 = 6'd0; Y1 = 6'd63; COLOR = 8'hFF;
            end
            @(negedge CLK);
            exp_we = (idx < exp_q.size()) && (exp_q[idx].cyc == c);
            check($sformatf("%s.c%0d.we", tag, c), {31'd0, FB_WE}, {31'd0, exp_we});
            if (exp_we) begin
                check($sformatf("%s.c%0d.wa", tag, c), {19'd0, FB_WA}, {19'd0, exp_q[idx].wa});
                check($sformatf("%s.c%0d.wd", tag, c), {24'd0, FB_WD}, {24'd0, exp_q[idx].wd});
                idx++;
            end
            check($sformatf("%s.c%0d.busy", tag, c), {31'd0, BUSY},
                  {31'd0, (c >= busy_lo && c <= busy_hi)});
            check($sformatf("%s.c%0d.done", tag, c), {31'd0, DONE}, {31'd0, (c == done_cyc)});
            if (rst_cyc >= 0 && c == rst_cyc + 1) begin
                check({tag, ".rst_wa"}, {19'd0, FB_WA}, 32'd0);
                check({tag, ".rst_wd"}, {24'd0, FB_WD}, 32'd0);
            end
            @(posedge CLK);
            #1;
        end
        START  = 1'b0;
        RST    = 1'b0;
        CPU_WE = 1'b0;
        check({tag, ".nwr"}, idx, exp_q.size());
    endtask

    initial begin
        RST = 1'b1; CPU_WE = 1'b0; CPU_WA = '0; CPU_WD = '0; START = 1'b0;
        X0 = '0; X1 = '0; Y0 = '0; Y1 = '0; COLOR = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset.we",   {31'd0, FB_WE}, 32'd0);
        check("reset.wa",   {19'd0, FB_WA}, 32'd0);
        check("reset.wd",   {24'd0, FB_WD}, 32'd0);
        check("reset.busy", {31'd0, BUSY},  32'd0);
        check("reset.done", {31'd0, DONE},  32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Basic 3x2 fill.
        exp_q.delete();
        expect_wr(2, 13'h502, 8'hE0); expect_wr(3, 13'h503, 8'hE0);
        expect_wr(4, 13'h504, 8'hE0); expect_wr(5, 13'h582, 8'hE0);
        expect_wr(6, 13'h583, 8'hE0); expect_wr(7, 13'h584, 8'hE0);
        run_case("fill", 7'd2, 7'd4, 6'd10, 6'd11, 8'hE0,
                 -1, '0, '0, -1, -1, 1, 7, 8, 10);

        // CPU write arbitrated in cycle 3 lands in cycle 4 and pushes the fill back one cycle.
        exp_q.delete();
        expect_wr(2, 13'h502, 8'hE0); expect_wr(3, 13'h503, 8'hE0);
        expect_wr(4, 13'h000, 8'h1C); expect_wr(5, 13'h504, 8'hE0);
        expect_wr(6, 13'h582, 8'hE0); expect_wr(7, 13'h583, 8'hE0);
        expect_wr(8, 13'h584, 8'hE0);
        run_case("cpu", 7'd2, 7'd4, 6'd10, 6'd11, 8'hE0,
                 3, 13'h000, 8'h1C, -1, -1, 1, 8, 9, 11);

        // Clamp: x 78..79, y 59 -> {59,78}=0x1DCE, {59,79}=0x1DCF.
        exp_q.delete();
        expect_wr(2, 13'h1DCE, 8'h5A); expect_wr(3, 13'h1DCF, 8'h5A);
        run_case("clamp", 7'd78, 7'd127, 6'd59, 6'd63, 8'h5A,
                 -1, '0, '0, -1, -1, 1, 3, 4, 6);

        exp_q.delete();
        run_case("empty", 7'd5, 7'd3, 6'd0, 6'd0, 8'h77,
                 -1, '0, '0, -1, -1, 1, 0, 1, 4);

        exp_q.delete();
        run_case("empty_x", 7'd80, 7'd90, 6'd0, 6'd0, 8'h77,
                 -1, '0, '0, -1, -1, 1, 0, 1, 3);

        // START pulsed again in cycle 3 with the junk rectangle.
        exp_q.delete();
        expect_wr(2, 13'h502, 8'hE0); expect_wr(3, 13'h503, 8'hE0);
        expect_wr(4, 13'h504, 8'hE0); expect_wr(5, 13'h582, 8'hE0);
        expect_wr(6, 13'h583, 8'hE0); expect_wr(7, 13'h584, 8'hE0);
        run_case("restart", 7'd2, 7'd4, 6'd10, 6'd11, 8'hE0,
                 -1, '0, '0, 3, -1, 1, 7, 8, 10);

        // Single pixel {20,10} = 0xA0A.
        exp_q.delete();
        expect_wr(2, 13'h0A0A, 8'h33);
        run_case("single", 7'd10, 7'd10, 6'd20, 6'd20, 8'h33,
                 -1, '0, '0, -1, -1, 1, 2, 3, 5);

        // START and CPU_WE together.
        exp_q.delete();
        expect_wr(1, 13'h07FF, 8'h11);
        expect_wr(2, 13'h0000, 8'h22); expect_wr(3, 13'h0001, 8'h22);
        run_case("start_cpu", 7'd0, 7'd1, 6'd0, 6'd0, 8'h22,
                 0, 13'h07FF, 8'h11, -1, -1, 1, 3, 4, 6);

        // Reset in cycle 3 aborts the fill; only the later CPU write appears.
        exp_q.delete();
        expect_wr(2, 13'h502, 8'hE0); expect_wr(3, 13'h503, 8'hE0);
        expect_wr(7, 13'h123, 8'h3C);
        run_case("midrst", 7'd2, 7'd4, 6'd10, 6'd11, 8'hE0,
                 6, 13'h123, 8'h3C, -1, 3, 1, 3, -1, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
